// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and pixel scanout from a show-ahead video FIFO.
// Counters advance on pix_en; every vga_* output is registered one clk after the
// counter values it represents. Starved visible pixels are dropped (black) and counted.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [23:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_start,
    input  logic        underflow_clr,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    // One spare bit so the sync end bound still fits when the back porch is zero.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FP + V_SYNC);

    // Saturating increment for the underflow counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_n_q, blank_n_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   ucnt_q, ucnt_d;
    logic          visible;
    logic          starve;

    // Region decode on the current counters and the FIFO pop strobe.
    always_comb begin
        visible    = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
        starve     = pix_en && visible && fifo_empty;
        fifo_rdreq = !rst && pix_en && visible && !fifo_empty;
    end

    // Next-state: counters, registered video outputs and the underflow counter.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_n_d     = blank_n_q;
        frame_start_d = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
        if (pix_en) begin
            rgb_d     = (visible && !fifo_empty) ? fifo_q : 24'h0;
            blank_n_d = visible;
            hsync_d   = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
            vsync_d   = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
        // A clear on the same cycle as a starved pixel wins.
        if (underflow_clr) begin
            ucnt_d = 16'h0;
        end else if (starve) begin
            ucnt_d = sat_inc(ucnt_q);
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // State registers; reset aborts the scan and returns to the top-left corner.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= 24'h0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            ucnt_q        <= 16'h0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
            ucnt_q        <= ucnt_d;
        end
    end

    assign vga_r         = rgb_q[23:16];
    assign vga_g         = rgb_q[15:8];
    assign vga_b         = rgb_q[7:0];
    assign vga_hsync     = hsync_q;
    assign vga_vsync     = vsync_q;
    assign vga_blank_n   = blank_n_q;
    assign frame_start   = frame_start_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout on a reduced 64x64 raster
// (60 visible, porches 1/2/1 in both directions) so a frame is 4096 pixels.
module tb_vga_scanout;

    localparam int HV = 60;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int VV = 60;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [23:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic        frame_start;
    logic        underflow_clr;
    logic [15:0] underflow_cnt;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .fifo_q(fifo_q),
        .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n),
        .frame_start(frame_start),
        .underflow_clr(underflow_clr),
        .underflow_cnt(underflow_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference raster position and expected registered outputs.
    int          th;
    int          tv;
    logic [23:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
    logic        e_blank;
    logic        e_fs;
    logic [15:0] e_uc;
    logic        saw_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("vga_r", 32'(vga_r), 32'(e_rgb[23:16]));
        chk("vga_g", 32'(vga_g), 32'(e_rgb[15:8]));
        chk("vga_b", 32'(vga_b), 32'(e_rgb[7:0]));
        chk("hsync", 32'(vga_hsync), 32'(e_hs));
        chk("vsync", 32'(vga_vsync), 32'(e_vs));
        chk("blank_n", 32'(vga_blank_n), 32'(e_blank));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(e_uc));
    endtask

    // One clk of stimulus; the reference position advances only when pe=1.
    task automatic drive(input logic pe, input logic emp, input logic [23:0] q,
                         input logic clr, input bit ck);
        logic vis;
        pix_en        = pe;
        fifo_empty    = emp;
        fifo_q        = q;
        underflow_clr = clr;
        #1;
        vis     = (th < HV) && (tv < VV);
        saw_pop = fifo_rdreq;
        if (ck) chk("rdreq", 32'(fifo_rdreq), 32'(pe && vis && !emp));
        @(posedge clk);
        #1;
        e_fs = pe && (th == 0) && (tv == 0);
        if (pe) begin
            e_rgb   = (vis && !emp) ? q : 24'h0;
            e_blank = vis;
            e_hs    = !((th >= HV + HF) && (th < HV + HF + HS));
            e_vs    = !((tv >= VV + VF) && (tv < VV + VF + VS));
            if (th == HT - 1) begin
                th = 0;
                tv = (tv == VT - 1) ? 0 : tv + 1;
            end else begin
                th++;
            end
        end
        if (clr) e_uc = 16'h0;
        else if (pe && vis && emp && e_uc != 16'hFFFF) e_uc++;
        if (ck) check_outs();
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b1;
        pix_en        = 1'b1;
        fifo_empty    = 1'b0;
        fifo_q        = 24'hABCDEF;
        underflow_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
            @(posedge clk);
            #1;
            th = 0; tv = 0;
            e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_fs = 1'b0; e_uc = 16'h0;
            check_outs();
        end
        rst    = 1'b0;
        pix_en = 1'b0;
    endtask

    initial begin
        int n;
        int pops;
        int clks;
        int hsl;
        int vsl;
        int nf;
        int cyc;
        int fall_t[2];
        logic prev_hs;

        rst = 1'b1; pix_en = 1'b0; fifo_q = 24'h0; fifo_empty = 1'b1; underflow_clr = 1'b0;
        th = 0; tv = 0; e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
        e_fs = 1'b0; e_uc = 16'h0; saw_pop = 1'b0;

        // Reset values, then one idle clk after release.
        do_reset(3);
        drive(1'b0, 1'b0, 24'h0F0F0F, 1'b0, 1'b1);
        chk("post_rst_blank", 32'(vga_blank_n), 32'd0);
        chk("post_rst_hsync", 32'(vga_hsync), 32'd1);

        // First pixel of the frame appears one clk later.
        drive(1'b1, 1'b0, 24'h123456, 1'b0, 1'b1);
        chk("px0_r", 32'(vga_r), 32'h12);
        chk("px0_g", 32'(vga_g), 32'h34);
        chk("px0_b", 32'(vga_b), 32'h56);
        chk("px0_blank", 32'(vga_blank_n), 32'd1);
        chk("px0_fs", 32'(frame_start), 32'd1);
        drive(1'b0, 1'b0, 24'h999999, 1'b0, 1'b1);
        chk("hold_fs", 32'(frame_start), 32'd0);
        chk("hold_r", 32'(vga_r), 32'h12);

        for (int h = 1; h < HV; h++) drive(1'b1, 1'b0, {8'(h), 8'h5A, 8'hC3}, 1'b0, 1'b1);
        chk("px59_r", 32'(vga_r), 32'd59);
        drive(1'b1, 1'b0, 24'h777777, 1'b0, 1'b1);
        chk("h60_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("h60_blank", 32'(vga_blank_n), 32'd0);
        drive(1'b1, 1'b0, 24'h777777, 1'b0, 1'b1);
        chk("h61_hsync", 32'(vga_hsync), 32'd0);
        drive(1'b1, 1'b0, 24'h777777, 1'b0, 1'b1);
        chk("h62_hsync", 32'(vga_hsync), 32'd0);
        drive(1'b1, 1'b0, 24'h777777, 1'b0, 1'b1);
        chk("h63_hsync", 32'(vga_hsync), 32'd1);

        // Underflow: five starved pixels mid-line, then clear with a sixth.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 24'h010203 + 24'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b1);
        chk("uf_cnt5", 32'(underflow_cnt), 32'd5);
        chk("uf_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        drive(1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1);
        chk("uf_clr", 32'(underflow_cnt), 32'd0);
        drive(1'b1, 1'b0, 24'h00BEEF, 1'b0, 1'b1);
        chk("uf_resume", {8'h0, vga_r, vga_g, vga_b}, 32'h00BEEF);

        // Full frame between consecutive frame_start pulses.
        n = 0;
        while (frame_start !== 1'b1 && n < 5000) begin
            drive(1'b1, 1'b0, 24'h400000 + 24'(n), 1'b0, 1'b1);
            n++;
        end
        chk("frame_fs_seen", 32'(frame_start), 32'd1);
        pops = 0; clks = 0; hsl = 0; vsl = 0;
        do begin
            drive(1'b1, 1'b0, 24'h200000 + 24'(clks), 1'b0, 1'b1);
            clks++;
            pops += int'(saw_pop);
            hsl  += int'(!vga_hsync);
            vsl  += int'(!vga_vsync);
        end while (frame_start !== 1'b1 && clks < 5000);
        chk("frame_clks", 32'(clks), 32'd4096);
        chk("frame_pops", 32'(pops), 32'd3600);
        chk("frame_hsync_low", 32'(hsl), 32'd128);
        chk("frame_vsync_low", 32'(vsl), 32'd128);

        // Reset mid-frame at h=30, v=20.
        n = 0;
        while (!(th == 30 && tv == 20) && n < 5000) begin
            drive(1'b1, 1'b0, 24'h330000 + 24'(n), 1'b0, 1'b0);
            n++;
        end
        do_reset(3);
        drive(1'b0, 1'b0, 24'h555555, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 24'hABCDEF, 1'b0, 1'b1);
        chk("rst_fs", 32'(frame_start), 32'd1);
        chk("rst_first_px", {8'h0, vga_r, vga_g, vga_b}, 32'hABCDEF);

        // Half-rate pixel enable: single-clk frame_start and 128-clk line period.
        drive(1'b0, 1'b0, 24'h666666, 1'b0, 1'b1);
        chk("half_fs_1clk", 32'(frame_start), 32'd0);
        nf = 0; cyc = 0; fall_t[0] = 0; fall_t[1] = 0; prev_hs = vga_hsync;
        while (nf < 2 && cyc < 1000) begin
            drive(1'((cyc % 2) == 0), 1'b0, 24'h700000 + 24'(cyc), 1'b0, 1'b1);
            cyc++;
            if (prev_hs && !vga_hsync) begin
                fall_t[nf] = cyc;
                nf++;
            end
            prev_hs = vga_hsync;
        end
        chk("half_line_period", 32'(fall_t[1] - fall_t[0]), 32'd128);

        // Saturation of the underflow counter.
        n = 0;
        while (e_uc != 16'hFFFF && n < 90000) begin
            drive(1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
            n++;
        end
        chk("sat_reach", 32'(underflow_cnt), 32'hFFFF);
        n = 0;
        while (!((th < HV) && (tv < VV)) && n < 100) begin
            drive(1'b1, 1'b1, 24'h0, 1'b0, 1'b1);
            n++;
        end
        drive(1'b1, 1'b1, 24'h0, 1'b0, 1'b1);
        chk("sat_hold", 32'(underflow_cnt), 32'hFFFF);
        drive(1'b1, 1'b1, 24'h0, 1'b1, 1'b1);
        chk("sat_clr", 32'(underflow_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters: name, default, meaning.
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-002 Ports: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on the rising edge
- rst, in, 1, synchronous, active-high reset
- pix_en, in, 1, pixel-rate strobe; timing advances only on cycles where it is 1
- fifo_q, in, 24, video FIFO head word {R[23:16], G[15:8], B[7:0]}; show-ahead, valid whenever fifo_empty=0
- fifo_empty, in, 1, video FIFO empty
- fifo_rdreq, out, 1, pop strobe for the video FIFO head
- vga_r, out, 8, red output
- vga_g, out, 8, green output
- vga_b, out, 8, blue output
- vga_hsync, out, 1, horizontal sync, active low
- vga_vsync, out, 1, vertical sync, active low
- vga_blank_n, out, 1, 1 during the visible region
- frame_start, out, 1, one-clk pulse at the start of each frame
- underflow_clr, in, 1, clears underflow_cnt
- underflow_cnt, out, 16, saturating count of starved visible pixels

Function
REQ-003 Counters.
- h_cnt range: 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800).
- v_cnt range: 0..V_TOTAL-1, where V_TOTAL = sum of the V_* parameters (525).
- Counters change only on pix_en=1 cycles.
- h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt on that wrap.
- v_cnt wraps V_TOTAL-1 -> 0 when h_cnt also wraps.

REQ-004 visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE), evaluated on the current (pre-increment) counter values.

REQ-005 fifo_rdreq is combinational: pix_en && visible && !fifo_empty; it is never asserted when fifo_empty=1 or outside the visible region.

REQ-006 All vga_* outputs are registered and update only on pix_en cycles, one clk after the counter values they represent (latency 1 clk).

REQ-007 Visible cycle, fifo_empty=0: {vga_r, vga_g, vga_b} <= fifo_q on the same edge that pops the FIFO head.

REQ-008 Visible cycle, fifo_empty=1:
- {vga_r, vga_g, vga_b} <= 0
- no pop
- underflow_cnt increments by 1, saturating at 16'hFFFF
- the pixel is dropped; scan timing is not stalled

REQ-009 Non-visible cycle: RGB <= 0, vga_blank_n <= 0, no pop.

REQ-010 vga_hsync <= 0 when h_cnt is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [656, 752); 1 otherwise.

REQ-011 vga_vsync <= 0 when v_cnt is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. [490, 492); 1 otherwise.

REQ-012 frame_start <= 1 for exactly one clk on the edge where pix_en=1, h_cnt=0 and v_cnt=0; 0 on all other cycles, including pix_en=0 cycles.

REQ-013 Simultaneous underflow_clr and underflow event: the clear wins, so underflow_cnt = 0.

REQ-014 pix_en=0: counters, outputs and underflow_cnt hold; fifo_rdreq=0; underflow_clr still acts.

REQ-015 The FIFO is read in strict raster order; the block never reorders or duplicates a word.

Reset
REQ-016 While rst=1 and on the cycle after rst falls, the outputs are:
- h_cnt = 0, v_cnt = 0
- RGB = 0
- vga_hsync = 1, vga_vsync = 1
- vga_blank_n = 0
- frame_start = 0
- fifo_rdreq = 0
- underflow_cnt = 0

REQ-017 rst asserted mid-line or mid-frame aborts the scan immediately; the first pix_en after release is treated as h=0, v=0 and raises frame_start.

REQ-018 rst has priority over pix_en and underflow_clr.

Verification
REQ-019 Full frame.
- Stimulus: pix_en=1 every clk, FIFO always non-empty.
- Response: exactly 307200 fifo_rdreq pulses between consecutive frame_start pulses, which are 420000 clks apart.
- Response: hsync low for 96 pix_en per line starting at h=656; vsync low for lines 490-491.

REQ-020 Pixel path latency.
- Stimulus: fifo_q=24'h123456 at h=0, v=0.
- Response: next clk vga_r=8'h12, vga_g=8'h34, vga_b=8'h56, vga_blank_n=1.
- Stimulus: h=640.
- Response: RGB=0, blank_n=0, no rdreq.

REQ-021 Underflow.
- Stimulus: fifo_empty=1 for 5 visible pixels mid-line.
- Response: RGB=0 for those pixels, no rdreq, underflow_cnt=5, h_cnt keeps advancing.
- Stimulus: pulse underflow_clr together with a 6th starved pixel.
- Response: underflow_cnt=0.

REQ-022 Saturation.
- Stimulus: preload the counter to 16'hFFFF via 65535 starved pixels, then one more starved pixel.
- Response: underflow_cnt stays 16'hFFFF.

REQ-023 pix_en=1 every 2nd clk.
- Response: outputs change only on enable cycles.
- Response: frame_start lasts exactly 1 clk.
- Response: line period is 1600 clks.

REQ-024 Reset mid-frame.
- Stimulus: rst=1 for 3 clks at h=300, v=200.
- Response: outputs reach their REQ-016 values.
- Response: first pix_en after release gives frame_start=1 and the next pop is the first visible pixel of the new frame.
